// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Requester identifiers; also the index into the rr_arb2 request vector.
   localparam logic REQ_C = 1'b0;
   localparam logic REQ_V = 1'b1;

   // Transfer size encodings understood by the data memory.
   localparam logic [1:0] SZ_B  = 2'b00;
   localparam logic [1:0] SZ_H  = 2'b01;
   localparam logic [1:0] SZ_3B = 2'b10;
   localparam logic [1:0] SZ_W  = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       win,
   output logic       any
);

   // Pick the winner from the current request vector and the last grantee.
   always_comb begin
      any = req[REQ_C] | req[REQ_V];
      win = REQ_C;
      if (req[REQ_C] && req[REQ_V]) begin
         win = ~last;
      end else if (req[REQ_V]) begin
         win = REQ_V;
      end else begin
         win = REQ_C;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the CPU load/store unit (c_*)
// and the VGA framebuffer reader (v_*), one transaction at a time.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   input  logic [1:0]        c_size,
   input  logic              c_sign_ext,
   output logic              c_gnt,
   output logic              c_ack,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              v_req,
   input  logic              v_we,
   input  logic [ADDR_W-1:0] v_addr,
   input  logic [DATA_W-1:0] v_wdata,
   input  logic [1:0]        v_size,
   input  logic              v_sign_ext,
   output logic              v_gnt,
   output logic              v_ack,
   output logic [DATA_W-1:0] v_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic [1:0]        mem_size,
   output logic              mem_sign_ext,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   state_t            state, state_nxt;
   logic              last, last_nxt;
   logic              cur, cur_nxt;         // requester being served
   logic              cur_we, cur_we_nxt;   // latched direction of current transfer
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              c_gnt_nxt, v_gnt_nxt, c_ack_nxt, v_ack_nxt;
   logic [DATA_W-1:0] c_rdata_nxt, v_rdata_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic              we_nxt, sext_nxt, busy_nxt;
   logic [1:0]        size_nxt;
   logic              win, any;

   rr_arb2 u_rr_arb2 (
      .req  ({v_req, c_req}),
      .last (last),
      .win  (win),
      .any  (any)
   );

   // Next-state and next-output logic; mem_we, gnt and ack default low so each is a single pulse.
   always_comb begin
      state_nxt   = state;
      last_nxt    = last;
      cur_nxt     = cur;
      cur_we_nxt  = cur_we;
      cnt_nxt     = cnt;
      c_gnt_nxt   = 1'b0;
      v_gnt_nxt   = 1'b0;
      c_ack_nxt   = 1'b0;
      v_ack_nxt   = 1'b0;
      c_rdata_nxt = c_rdata;
      v_rdata_nxt = v_rdata;
      addr_nxt    = mem_addr;
      wdata_nxt   = mem_wdata;
      size_nxt    = mem_size;
      sext_nxt    = mem_sign_ext;
      we_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (any) begin
               state_nxt = ACCESS;
               last_nxt  = win;
               cur_nxt   = win;
               cnt_nxt   = '0;
               if (win == REQ_V) begin
                  addr_nxt   = v_addr;
                  wdata_nxt  = v_wdata;
                  size_nxt   = v_size;
                  sext_nxt   = v_sign_ext;
                  we_nxt     = v_we;
                  cur_we_nxt = v_we;
                  v_gnt_nxt  = 1'b1;
               end else begin
                  addr_nxt   = c_addr;
                  wdata_nxt  = c_wdata;
                  size_nxt   = c_size;
                  sext_nxt   = c_sign_ext;
                  we_nxt     = c_we;
                  cur_we_nxt = c_we;
                  c_gnt_nxt  = 1'b1;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         ACCESS: begin
            if (cnt == CNT_LAST) begin
               state_nxt = RESP;
               if (cur == REQ_V) begin
                  v_ack_nxt = 1'b1;
                  if (!cur_we) begin
                     v_rdata_nxt = mem_rdata;
                  end else begin
                     v_rdata_nxt = v_rdata;
                  end
               end else begin
                  c_ack_nxt = 1'b1;
                  if (!cur_we) begin
                     c_rdata_nxt = mem_rdata;
                  end else begin
                     c_rdata_nxt = c_rdata;
                  end
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // State and registered outputs; reset aborts any transfer and clears mem_we at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         last         <= REQ_V;
         cur          <= REQ_C;
         cur_we       <= 1'b0;
         cnt          <= '0;
         c_gnt        <= 1'b0;
         v_gnt        <= 1'b0;
         c_ack        <= 1'b0;
         v_ack        <= 1'b0;
         c_rdata      <= '0;
         v_rdata      <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_we       <= 1'b0;
         mem_size     <= SZ_W;
         mem_sign_ext <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         last         <= last_nxt;
         cur          <= cur_nxt;
         cur_we       <= cur_we_nxt;
         cnt          <= cnt_nxt;
         c_gnt        <= c_gnt_nxt;
         v_gnt        <= v_gnt_nxt;
         c_ack        <= c_ack_nxt;
         v_ack        <= v_ack_nxt;
         c_rdata      <= c_rdata_nxt;
         v_rdata      <= v_rdata_nxt;
         mem_addr     <= addr_nxt;
         mem_wdata    <= wdata_nxt;
         mem_we       <= we_nxt;
         mem_size     <= size_nxt;
         mem_sign_ext <= sext_nxt;
         busy         <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: one instance with MEM_LAT=1 and
// one with MEM_LAT=3, each attached to a small behavioural data memory.
module tb_data_mem_arbiter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // MEM_LAT=1 instance signals
   logic        c_req = 1'b0, c_we = 1'b0, c_sext = 1'b0;
   logic [31:0] c_addr = 32'h0, c_wdata = 32'h0;
   logic [1:0]  c_size = 2'b11;
   logic        v_req = 1'b0, v_we = 1'b0, v_sext = 1'b0;
   logic [31:0] v_addr = 32'h0, v_wdata = 32'h0;
   logic [1:0]  v_size = 2'b11;
   logic        c_gnt, c_ack, v_gnt, v_ack, mem_we, mem_sext, busy;
   logic [31:0] c_rdata, v_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_size;

   // MEM_LAT=3 instance signals (only the V port is exercised)
   logic        b_v_req = 1'b0, b_v_we = 1'b0, b_v_sext = 1'b0;
   logic [31:0] b_v_addr = 32'h0, b_v_wdata = 32'h0;
   logic [1:0]  b_v_size = 2'b11;
   logic        b_c_gnt, b_c_ack, b_v_gnt, b_v_ack, b_mem_we, b_mem_sext, b_busy;
   logic [31:0] b_c_rdata, b_v_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [1:0]  b_mem_size;

   logic [31:0] mem1 [0:255];
   logic [31:0] mem3 [0:255];

   int n_checks = 0;
   int n_errors = 0;

   data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
      .clock(clk), .reset_n(reset_n),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_size(c_size),
      .c_sign_ext(c_sext), .c_gnt(c_gnt), .c_ack(c_ack), .c_rdata(c_rdata),
      .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata), .v_size(v_size),
      .v_sign_ext(v_sext), .v_gnt(v_gnt), .v_ack(v_ack), .v_rdata(v_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_size(mem_size),
      .mem_sign_ext(mem_sext), .mem_rdata(mem_rdata), .busy(busy)
   );

   data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
      .clock(clk), .reset_n(reset_n),
      .c_req(1'b0), .c_we(1'b0), .c_addr(32'h0), .c_wdata(32'h0), .c_size(2'b11),
      .c_sign_ext(1'b0), .c_gnt(b_c_gnt), .c_ack(b_c_ack), .c_rdata(b_c_rdata),
      .v_req(b_v_req), .v_we(b_v_we), .v_addr(b_v_addr), .v_wdata(b_v_wdata), .v_size(b_v_size),
      .v_sign_ext(b_v_sext), .v_gnt(b_v_gnt), .v_ack(b_v_ack), .v_rdata(b_v_rdata),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_size(b_mem_size),
      .mem_sign_ext(b_mem_sext), .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   // Memory read formatting: narrow reads take the low bytes, optionally sign-extended.
   function automatic logic [31:0] rd_fmt(input logic [31:0] w, input logic [1:0] sz, input logic se);
      case (sz)
         2'b00:   rd_fmt = se ? {{24{w[7]}},  w[7:0]}  : {24'h0, w[7:0]};
         2'b01:   rd_fmt = se ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
         2'b10:   rd_fmt = se ? {{8{w[23]}},  w[23:0]} : {8'h0,  w[23:0]};
         default: rd_fmt = w;
      endcase
   endfunction

   // Memory write merge: narrow writes replace only the low bytes.
   function automatic logic [31:0] wr_merge(input logic [31:0] old, input logic [31:0] wd, input logic [1:0] sz);
      case (sz)
         2'b00:   wr_merge = {old[31:8],  wd[7:0]};
         2'b01:   wr_merge = {old[31:16], wd[15:0]};
         2'b10:   wr_merge = {old[31:24], wd[23:0]};
         default: wr_merge = wd;
      endcase
   endfunction

   assign mem_rdata   = rd_fmt(mem1[mem_addr[7:0]], mem_size, mem_sext);
   assign b_mem_rdata = rd_fmt(mem3[b_mem_addr[7:0]], b_mem_size, b_mem_sext);

   // Behavioural memories write on the falling edge while we is high.
   always @(negedge clk) begin
      if (mem_we) mem1[mem_addr[7:0]] <= wr_merge(mem1[mem_addr[7:0]], mem_wdata, mem_size);
      if (b_mem_we) mem3[b_mem_addr[7:0]] <= wr_merge(mem3[b_mem_addr[7:0]], b_mem_wdata, b_mem_size);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        port;   // 0 = C, 1 = V
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   // Single-requester transaction on the MEM_LAT=1 instance.
   task automatic do_vec(input vec_t t);
      int gc, ac, other;
      logic [31:0] ma;
      logic [1:0] ms;
      gc = -1; ac = -1; other = 0; ma = 32'h0; ms = 2'b00;
      if (t.port) begin
         v_req = 1'b1; v_we = t.we; v_addr = t.addr; v_wdata = t.wdata; v_size = t.size; v_sext = t.sext;
      end else begin
         c_req = 1'b1; c_we = t.we; c_addr = t.addr; c_wdata = t.wdata; c_size = t.size; c_sext = t.sext;
      end
      for (int k = 1; k <= 10 && ac < 0; k++) begin
         @(posedge clk); #1;
         if ((t.port && v_gnt) || (!t.port && c_gnt)) begin
            gc = k; ma = mem_addr; ms = mem_size;
         end
         if ((t.port && v_ack) || (!t.port && c_ack)) ac = k;
         if ((t.port && (c_gnt || c_ack)) || (!t.port && (v_gnt || v_ack))) other = 1;
      end
      c_req = 1'b0; v_req = 1'b0;
      chk("gnt_latency", 32'(gc), 32'd1);
      chk("ack_latency", 32'(ac), 32'd2);
      chk("mem_addr", ma, t.addr);
      chk("mem_size", {30'h0, ms}, {30'h0, t.size});
      chk("rdata", t.port ? v_rdata : c_rdata, t.exp_rdata);
      chk("other_port_idle", 32'(other), 32'd0);
      @(posedge clk); #1;
      chk("busy_after", {31'h0, busy}, 32'd0);
   endtask

   initial begin
      int gi, ac, wec;
      logic [31:0] exp3;

      vecs[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0, 32'h00000000};
      vecs[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        2'b11, 1'b0, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 32'h30, 32'h00000080, 2'b11, 1'b0, 32'h00000000};
      vecs[3] = '{1'b1, 1'b0, 32'h30, 32'h0,        2'b00, 1'b1, 32'hFFFFFF80};
      vecs[4] = '{1'b0, 1'b0, 32'h30, 32'h0,        2'b00, 1'b0, 32'h00000080};
      vecs[5] = '{1'b0, 1'b1, 32'h10, 32'h12345678, 2'b00, 1'b0, 32'h00000080};
      vecs[6] = '{1'b0, 1'b0, 32'h10, 32'h0,        2'b01, 1'b1, 32'hFFFFBE78};
      vecs[7] = '{1'b1, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h00ADBE78};
      vecs[8] = '{1'b1, 1'b0, 32'h10, 32'h0,        2'b11, 1'b0, 32'hDEADBE78};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
      chk("rst_mem_size", {30'h0, mem_size}, 32'd3);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_gnt_ack", {28'h0, c_gnt, c_ack, v_gnt, v_ack}, 32'h0);
      chk("rst_rdata", c_rdata | v_rdata, 32'h0);
      reset_n = 1'b1;

      // Directed single-requester vectors
      for (int i = 0; i < 9; i++) begin
         do_vec(vecs[i]);
      end

      // Both requesters held after reset: C first, then strict alternation every 3 cycles
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_size = 2'b11; c_sext = 1'b0;
      v_req = 1'b1; v_we = 1'b0; v_addr = 32'h30; v_size = 2'b11; v_sext = 1'b0;
      gi = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (c_gnt && v_gnt) chk("dual_gnt", 32'd1, 32'd0);
         if (c_gnt || v_gnt) begin
            chk("alt_who", {31'h0, v_gnt}, 32'(gi % 2));
            chk("alt_cycle", 32'(k), 32'(1 + 3 * gi));
            gi++;
         end
      end
      c_req = 1'b0; v_req = 1'b0;
      chk("alt_count", 32'(gi), 32'd4);
      chk("alt_c_rdata", c_rdata, 32'hDEADBE78);
      chk("alt_v_rdata", v_rdata, 32'h00000080);

      // MEM_LAT=3 write: mem_we for one cycle, ack after 4 cycles, rdata untouched
      @(posedge clk); #1;
      b_v_req = 1'b1; b_v_we = 1'b1; b_v_addr = 32'h20; b_v_wdata = 32'h000000A5; b_v_size = 2'b00;
      wec = 0; ac = -1;
      for (int k = 1; k <= 10 && ac < 0; k++) begin
         @(posedge clk); #1;
         if (b_mem_we) wec++;
         if (b_v_ack) ac = k;
      end
      b_v_req = 1'b0;
      chk("lat3_we_cycles", 32'(wec), 32'd1);
      chk("lat3_ack_latency", 32'(ac), 32'd4);
      chk("lat3_rdata_kept", b_v_rdata, 32'h0);
      chk("lat3_busy_resp", {31'h0, b_busy}, 32'd1);

      // MEM_LAT=3 byte reads of the written byte, unsigned then signed
      for (int j = 0; j < 2; j++) begin
         @(posedge clk); #1;
         b_v_req = 1'b1; b_v_we = 1'b0; b_v_addr = 32'h20; b_v_size = 2'b00; b_v_sext = (j == 1);
         exp3 = (j == 1) ? 32'hFFFFFFA5 : 32'h000000A5;
         ac = -1;
         for (int k = 1; k <= 10 && ac < 0; k++) begin
            @(posedge clk); #1;
            if (b_v_ack) ac = k;
         end
         b_v_req = 1'b0;
         chk("lat3_rd_latency", 32'(ac), 32'd4);
         chk("lat3_rd_data", b_v_rdata, exp3);
      end

      // Reset during the ACCESS cycle of a C write: immediate abort, then C wins the tie
      @(posedge clk); #1;
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'h11111111; c_size = 2'b11;
      @(posedge clk); #1;
      chk("abort_gnt", {31'h0, c_gnt}, 32'd1);
      chk("abort_we_before", {31'h0, mem_we}, 32'd1);
      c_req = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("abort_we_now", {31'h0, mem_we}, 32'd0);
      chk("abort_busy", {31'h0, busy}, 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk("abort_no_ack", {30'h0, c_ack, v_ack}, 32'd0);
      end
      reset_n = 1'b1;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_size = 2'b11;
      v_req = 1'b1; v_we = 1'b0; v_addr = 32'h30; v_size = 2'b11;
      @(posedge clk); #1;
      chk("post_rst_tie", {30'h0, c_gnt, v_gnt}, 32'h2);
      c_req = 1'b0; v_req = 1'b0;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
